usr_serial_collector: RTL and testbench
=======================================

// Module: usr_serial_collector
// PURPOSE
//  Receive end of the universal shift register's serial output: gathers a serial
//  bit stream into WIDTH-bit parallel words. Mode encoding s[1:0] matches the USR
//  mux select: 00 hold, 01 shift-right in, 10 shift-left in, 11 clear.
//  Completed words are held in an output register and released on a valid/ready handshake.
// PARAMETERS
//  WIDTH  4  bits per parallel word (>=2); counter width $clog2(WIDTH+2)
// PORTS
//  clk        in   1      system clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  s          in   2      mode: 00 hold, 01 shift-right, 10 shift-left, 11 clear
//  sin        in   1      serial data bit, sampled when s is 01 or 10
//  out_data   out  WIDTH  completed word, stable while out_valid=1
//  out_valid  out  1      word available in output register
//  out_ready  in   1      consumer accepts word when out_valid & out_ready
//  overrun    out  1      sticky: a completed word was dropped
// BEHAVIOUR
//  - Reset: shreg=0, bit count=0, out_data=0, out_valid=0, overrun=0 (parity_err=0).
//  - s=00: shreg and count hold. s=11: shreg=0, count=0, overrun cleared;
//    output register and out_valid untouched.
//  - s=01: shreg <= {sin, shreg[WIDTH-1:1]}; s=10: shreg <= {shreg[WIDTH-2:0], sin};
//    count+1 per shift. Direction may change mid-word; count continues.
//  - Word complete on the shift that brings count to WIDTH: count wraps to 0 same
//    edge; the new word (including that bit) is written to out_data.
//    out_valid=1 from the next cycle (1-cycle latency after last bit).
//  - Handshake: out_valid drops the cycle after out_valid & out_ready,
//    unless a new word completes on the same edge. Then out_data loads the new
//    word and out_valid stays 1 (no bubble, no overrun).
//  - Word completes while out_valid=1 and out_ready=0: new word dropped, out_data
//    keeps old word, overrun=1 (sticky until rst or s=11). Count still wraps to 0.
//  - out_ready while out_valid=0: ignored.
//  - rst mid-word or mid-handshake: all state returns to reset values; partial word discarded.
// CONFIGURATION
//  USR_COLLECT_PARITY_EN defined:
//   - Each frame is WIDTH data bits followed by 1 even-parity bit; count spans
//     0..WIDTH, and the parity shift does not enter shreg.
//   - Word completes on the parity bit.
//   - Extra port parity_err (out, 1) is loaded with out_data:
//     1 if ^{data,parity} != 0, and is cleared by reset.
//  USR_COLLECT_PARITY_EN undefined:
//   - Word completes after WIDTH bits.
//   - No parity_err port and no parity logic.
// TESTING (WIDTH=4)
//  1. rst=1 two cycles, s=01, sin=1 -> out_valid=0, out_data=4'h0, overrun=0, count stays 0
//  2. out_ready=1, s=01, sin=1,0,1,1 -> out_data=4'hD, out_valid=1 one cycle after 4th bit,
//     drops next cycle
//  3. s=10, sin=1,0,1,1 with s=00 cycles interleaved -> out_data=4'hB;
//     hold cycles add no count
//  4. out_ready=0, s=10 words 4'h3 then 4'h5 -> out_data=4'h3, overrun=1;
//     then s=11 -> overrun=0, out_data=4'h3 and out_valid=1 retained
//  5. s=10, two bits, then s=11, then four bits 0,1,1,0 -> out_data=4'h6;
//     pending word accepted on the same edge as next word completes -> out_valid stays 1
//  6. PARITY_EN, s=10, bits 1,0,1,1 then parity 0 -> out_data=4'hB, parity_err=1;
//     parity 1 -> parity_err=0

Source files
------------

// File: rtl/usr_serial_collector.sv
// Serial-to-parallel collector for the USR serial output, with a valid/ready output register.
// Optional even-parity framing is enabled with `define USR_COLLECT_PARITY_EN.
module usr_serial_collector #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       s,
  input  logic             sin,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
`ifdef USR_COLLECT_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
`ifdef USR_COLLECT_PARITY_EN
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);
`endif

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;

  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_shreg_next;
  logic [WIDTH-1:0] w_word;

  assign w_shift = (s == 2'b01) || (s == 2'b10);
  assign w_last  = w_shift && (r_count == LastCnt);

  always_comb begin
    w_shifted = r_shreg;
    if (s == 2'b01) begin
      w_shifted = {sin, r_shreg[WIDTH-1:1]};
    end else if (s == 2'b10) begin
      w_shifted = {r_shreg[WIDTH-2:0], sin};
    end
  end

`ifdef USR_COLLECT_PARITY_EN
  // The parity bit closes the frame but never enters the data register.
  assign w_shreg_next = w_last ? r_shreg : w_shifted;
  assign w_word       = r_shreg;
  logic r_parity_err;
  assign parity_err   = r_parity_err;
`else
  assign w_shreg_next = w_shifted;
  assign w_word       = w_shifted;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg      <= '0;
      r_count      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef USR_COLLECT_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      case (s)
        2'b11: begin
          r_shreg   <= '0;
          r_count   <= '0;
          r_overrun <= 1'b0;
        end
        2'b01, 2'b10: begin
          r_shreg <= w_shreg_next;
          r_count <= w_last ? '0 : r_count + CW'(1);
        end
        default: ;
      endcase

      // A completing word may replace one being accepted on the same edge.
      if (w_last) begin
        if (!r_valid || out_ready) begin
          r_data       <= w_word;
          r_valid      <= 1'b1;
`ifdef USR_COLLECT_PARITY_EN
          r_parity_err <= ^{r_shreg, sin};
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_usr_serial_collector.sv
// Directed self-checking bench for usr_serial_collector (WIDTH=4).
// Frames gain a trailing parity bit when USR_COLLECT_PARITY_EN is defined.
module tb_usr_serial_collector;

  logic       clk;
  logic       rst;
  logic [1:0] s;
  logic       sin;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       overrun;
`ifdef USR_COLLECT_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  usr_serial_collector #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s),
    .sin       (sin),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef USR_COLLECT_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and return 1 time unit after the rising edge.
  task automatic drive(input logic [1:0] ms, input logic b, input logic rdy);
    @(negedge clk);
    s         = ms;
    sin       = b;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Final bit of a word; with parity framing the parity bit carries the ready value.
  task automatic last_bit(input logic [1:0] ms, input logic b, input logic par, input logic rdy);
`ifdef USR_COLLECT_PARITY_EN
    drive(ms, b, 1'b0);
    drive(ms, par, rdy);
`else
    if (par === 1'bx) $display("unused parity arg");
    drive(ms, b, rdy);
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(2'b01, 1'b1, 1'b0);
    drive(2'b01, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (out_data !== 4'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", out_data);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_shift_right;
    drive(2'b01, 1'b1, 1'b1);
    drive(2'b01, 1'b0, 1'b1);
    drive(2'b01, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL sr_early_valid: got %b want 0", out_valid);
    end
    last_bit(2'b01, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hD) begin
      n_fail++; $display("FAIL sr_word: got v=%b d=%h want v=1 d=d", out_valid, out_data);
    end
    drive(2'b00, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL sr_drop: got %b want 0", out_valid);
    end
  endtask

  task automatic test_shift_left_hold;
    drive(2'b10, 1'b1, 1'b1);
    drive(2'b00, 1'b0, 1'b1);
    drive(2'b10, 1'b0, 1'b1);
    drive(2'b00, 1'b1, 1'b1);
    drive(2'b00, 1'b1, 1'b1);
    drive(2'b10, 1'b1, 1'b1);
    drive(2'b00, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL sl_hold_valid: got %b want 0", out_valid);
    end
    last_bit(2'b10, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hB) begin
      n_fail++; $display("FAIL sl_word: got v=%b d=%h want v=1 d=b", out_valid, out_data);
    end
    drive(2'b00, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL sl_drop: got %b want 0", out_valid);
    end
  endtask

  task automatic test_overrun;
    drive(2'b10, 1'b0, 1'b0);
    drive(2'b10, 1'b0, 1'b0);
    drive(2'b10, 1'b1, 1'b0);
    last_bit(2'b10, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: got v=%b d=%h o=%b want 1 3 0", out_valid, out_data, overrun);
    end
    drive(2'b10, 1'b0, 1'b0);
    drive(2'b10, 1'b1, 1'b0);
    drive(2'b10, 1'b0, 1'b0);
    last_bit(2'b10, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_drop: got v=%b d=%h o=%b want 1 3 1", out_valid, out_data, overrun);
    end
    drive(2'b00, 1'b0, 1'b0);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun);
    end
    drive(2'b11, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: got v=%b d=%h o=%b want 1 3 0", out_valid, out_data, overrun);
    end
  endtask

  task automatic test_back_to_back;
    drive(2'b10, 1'b1, 1'b0);
    drive(2'b10, 1'b1, 1'b0);
    drive(2'b11, 1'b0, 1'b0);
    drive(2'b10, 1'b0, 1'b0);
    drive(2'b10, 1'b1, 1'b0);
    drive(2'b10, 1'b1, 1'b0);
    n_checks++;
    if (out_data !== 4'h3 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL b2b_pending: got d=%h o=%b want 3 0", out_data, overrun);
    end
    last_bit(2'b10, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h6 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_word: got v=%b d=%h o=%b want 1 6 0", out_valid, out_data, overrun);
    end
    drive(2'b00, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drop: got %b want 0", out_valid);
    end
  endtask

  task automatic test_mid_reset;
    drive(2'b01, 1'b1, 1'b0);
    drive(2'b01, 1'b1, 1'b0);
    drive(2'b01, 1'b1, 1'b0);
    last_bit(2'b01, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hF) begin
      n_fail++; $display("FAIL mr_word: got v=%b d=%h want 1 f", out_valid, out_data);
    end
    drive(2'b01, 1'b1, 1'b0);
    drive(2'b01, 1'b0, 1'b0);
    rst = 1'b1;
    drive(2'b01, 1'b1, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_reset: got v=%b d=%h o=%b want 0 0 0", out_valid, out_data, overrun);
    end
    drive(2'b10, 1'b1, 1'b0);
    drive(2'b10, 1'b0, 1'b0);
    drive(2'b10, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mr_partial: got %b want 0", out_valid);
    end
    last_bit(2'b10, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h9) begin
      n_fail++; $display("FAIL mr_next: got v=%b d=%h want 1 9", out_valid, out_data);
    end
    drive(2'b00, 1'b0, 1'b1);
  endtask

`ifdef USR_COLLECT_PARITY_EN
  task automatic test_parity;
    drive(2'b10, 1'b1, 1'b1);
    drive(2'b10, 1'b0, 1'b1);
    drive(2'b10, 1'b1, 1'b1);
    last_bit(2'b10, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (out_data !== 4'hB || parity_err !== 1'b1) begin
      n_fail++; $display("FAIL par_bad: got d=%h e=%b want b 1", out_data, parity_err);
    end
    drive(2'b10, 1'b1, 1'b1);
    drive(2'b10, 1'b0, 1'b1);
    drive(2'b10, 1'b1, 1'b1);
    last_bit(2'b10, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (out_data !== 4'hB || parity_err !== 1'b0) begin
      n_fail++; $display("FAIL par_good: got d=%h e=%b want b 0", out_data, parity_err);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    s         = 2'b00;
    sin       = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_shift_right();
    test_shift_left_hold();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
`ifdef USR_COLLECT_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
